// File: rtl/adc_env_pkg.sv
// Shared configuration, FSM state encoding and the rectifier for the ADC envelope detector.
// All widths and constants for the block live here so the top and the ring RAM agree.
package adc_env_pkg;

   localparam int DATA_W    = 12;
   localparam int NUM_CH    = 8;
   localparam int WIN_LOG2  = 4;
   localparam int LED_W     = 6;
   localparam int CH_W      = $clog2(NUM_CH);
   localparam int SUM_W     = DATA_W + WIN_LOG2;
   localparam int ADDR_W    = CH_W + WIN_LOG2;
   localparam int RAM_DEPTH = NUM_CH << WIN_LOG2;
   localparam int LEVEL_W   = 3;

   localparam logic [DATA_W-1:0] BASELINE = DATA_W'(2048);
   localparam logic [DATA_W-1:0] HYST     = DATA_W'(64);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_READ,
      ST_UPDATE,
      ST_EMIT
   } state_t;

   // Distance from mid-scale; tops out at BASELINE (2048) for a zero sample.
   function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] sample);
      return (sample >= BASELINE) ? sample - BASELINE : BASELINE - sample;
   endfunction

endpackage

// File: rtl/env_ring_ram.sv
// Single-port synchronous RAM holding the per-channel sample windows, {channel, slot} addressed.
// Read data is registered (one cycle latency) and reflects the contents before a same-cycle write.
module env_ring_ram
   import adc_env_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   // NOTE: storage has no reset; the owner sweeps it to zero before first use, which keeps it a plain RAM.
   logic [DATA_W-1:0] r_mem [RAM_DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_envelope_detector.sv
// Per-channel moving-average envelope of |sample - BASELINE| with hysteresis detect flags
// and a thermometer LED bar for one selected channel. One sample every four cycles.
module adc_envelope_detector
   import adc_env_pkg::*;
(
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [CH_W-1:0]   s_channel,
   input  logic [DATA_W-1:0] s_data,
   input  logic              thresh_we,
   input  logic [CH_W-1:0]   thresh_ch,
   input  logic [DATA_W-1:0] thresh_data,
   input  logic [CH_W-1:0]   sel_ch,
   output logic              env_valid,
   output logic [CH_W-1:0]   env_channel,
   output logic [DATA_W-1:0] env_data,
   output logic [NUM_CH-1:0] detect,
   output logic [LED_W-1:0]  led_bar
);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_init_addr;
   logic [CH_W-1:0]     r_ch;
   logic [DATA_W-1:0]   r_rect;
   logic [SUM_W-1:0]    r_sum    [NUM_CH];
   logic [WIN_LOG2-1:0] r_wr_idx [NUM_CH];
   logic [DATA_W-1:0]   r_thresh [NUM_CH];

   logic                r_env_valid;
   logic [CH_W-1:0]     r_env_channel;
   logic [DATA_W-1:0]   r_env_data;
   logic [NUM_CH-1:0]   r_detect;
   logic [LED_W-1:0]    r_led_bar;

   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [DATA_W-1:0]   w_ram_wdata;
   logic [DATA_W-1:0]   w_ram_rdata;
   logic [ADDR_W-1:0]   w_slot_addr;
   logic [SUM_W-1:0]    w_new_sum;
   logic [DATA_W-1:0]   w_cur_thresh;
   logic [DATA_W-1:0]   w_clr_level;
   logic [NUM_CH-1:0]   w_detect_next;
   logic [LEVEL_W-1:0]  w_level;
   logic [LED_W-1:0]    w_led_next;
   logic                w_thresh_wr;

   env_ring_ram u_ring (
      .i_clk   (clk_clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   // Oldest sample of the window sits at the slot about to be overwritten.
   assign w_slot_addr = {r_ch, r_wr_idx[r_ch]};
   assign w_new_sum   = r_sum[r_ch] + SUM_W'(r_rect) - SUM_W'(w_ram_rdata);
   assign w_thresh_wr = thresh_we && (r_state != ST_INIT);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ram_we     = 1'b0;
      w_ram_addr   = '0;
      w_ram_wdata  = '0;
      case (r_state)
         ST_INIT: begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_init_addr;
            if (r_init_addr == ADDR_W'(RAM_DEPTH - 1)) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (s_valid) begin
               w_next_state = ST_READ;
            end
         end
         ST_READ: begin
            w_ram_addr   = w_slot_addr;
            w_next_state = ST_UPDATE;
         end
         ST_UPDATE: begin
            w_ram_we     = 1'b1;
            w_ram_addr   = w_slot_addr;
            w_ram_wdata  = r_rect;
            w_next_state = ST_EMIT;
         end
         ST_EMIT: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_INIT;
         end
      endcase
   end

   // Release level saturates at zero, so a low threshold latches the flag once set.
   assign w_cur_thresh = r_thresh[r_env_channel];
   assign w_clr_level  = (w_cur_thresh > HYST) ? w_cur_thresh - HYST : '0;

   always_comb begin
      w_detect_next = r_detect;
      if (r_state == ST_EMIT) begin
         if (r_env_data >= w_cur_thresh) begin
            w_detect_next[r_env_channel] = 1'b1;
         end else if (r_env_data < w_clr_level) begin
            w_detect_next[r_env_channel] = 1'b0;
         end
      end
      if (w_thresh_wr) begin
         w_detect_next[thresh_ch] = 1'b0;
      end
   end

   assign w_level = (r_env_data[DATA_W-1 -: LEVEL_W] > LEVEL_W'(LED_W)) ?
                    LEVEL_W'(LED_W) : r_env_data[DATA_W-1 -: LEVEL_W];

   always_comb begin
      w_led_next = '0;
      for (int i = 0; i < LED_W; i++) begin
         w_led_next[i] = (i < int'(w_level));
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state       <= ST_INIT;
         r_init_addr   <= '0;
         r_ch          <= '0;
         r_rect        <= '0;
         r_env_valid   <= 1'b0;
         r_env_channel <= '0;
         r_env_data    <= '0;
         r_detect      <= '0;
         r_led_bar     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_sum[c]    <= '0;
            r_wr_idx[c] <= '0;
            r_thresh[c] <= '0;
         end
      end else begin
         r_state     <= w_next_state;
         r_env_valid <= 1'b0;
         r_detect    <= w_detect_next;
         case (r_state)
            ST_INIT: begin
               r_init_addr <= r_init_addr + ADDR_W'(1);
            end
            ST_IDLE: begin
               if (s_valid) begin
                  r_ch   <= s_channel;
                  r_rect <= rectify(s_data);
               end
            end
            ST_UPDATE: begin
               r_sum[r_ch]    <= w_new_sum;
               r_wr_idx[r_ch] <= r_wr_idx[r_ch] + WIN_LOG2'(1);
               r_env_valid    <= 1'b1;
               r_env_channel  <= r_ch;
               r_env_data     <= w_new_sum[SUM_W-1:WIN_LOG2];
            end
            ST_EMIT: begin
               if (r_env_channel == sel_ch) begin
                  r_led_bar <= w_led_next;
               end
            end
            default: begin
            end
         endcase
         if (w_thresh_wr) begin
            r_thresh[thresh_ch] <= thresh_data;
         end
      end
   end

   assign s_ready     = (r_state == ST_IDLE);
   assign env_valid   = r_env_valid;
   assign env_channel = r_env_channel;
   assign env_data    = r_env_data;
   assign detect      = r_detect;
   assign led_bar     = r_led_bar;

endmodule

// File: tb/tb_adc_envelope_detector.sv
// Directed bench for adc_envelope_detector: init sweep, window ramps, hysteresis, wrap, LED bar, mid-sample reset.
module tb_adc_envelope_detector;
   import adc_env_pkg::*;

   logic              clk_clk     = 1'b0;
   logic              reset_reset = 1'b1;
   logic              s_valid     = 1'b0;
   logic              s_ready;
   logic [CH_W-1:0]   s_channel   = '0;
   logic [DATA_W-1:0] s_data      = '0;
   logic              thresh_we   = 1'b0;
   logic [CH_W-1:0]   thresh_ch   = '0;
   logic [DATA_W-1:0] thresh_data = '0;
   logic [CH_W-1:0]   sel_ch      = '0;
   logic              env_valid;
   logic [CH_W-1:0]   env_channel;
   logic [DATA_W-1:0] env_data;
   logic [NUM_CH-1:0] detect;
   logic [LED_W-1:0]  led_bar;

   int n_compared   = 0;
   int n_mismatched = 0;

   adc_envelope_detector u_dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_channel   (s_channel),
      .s_data      (s_data),
      .thresh_we   (thresh_we),
      .thresh_ch   (thresh_ch),
      .thresh_data (thresh_data),
      .sel_ch      (sel_ch),
      .env_valid   (env_valid),
      .env_channel (env_channel),
      .env_data    (env_data),
      .detect      (detect),
      .led_bar     (led_bar)
   );

   always #5 clk_clk = ~clk_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no summary by 500000, required finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Counts cycles until s_ready rises and notes whether any output was nonzero meanwhile.
   task automatic wait_init(output int cycles, output bit quiet);
      cycles = 0;
      quiet  = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_clk);
         if (s_ready) break;
         cycles++;
         if (env_valid || env_channel != '0 || env_data != '0 || detect != '0 || led_bar != '0)
            quiet = 1'b0;
      end
   endtask

   task automatic do_reset(input string tag);
      int cycles;
      bit quiet;
      reset_reset = 1'b1;
      s_valid     = 1'b0;
      thresh_we   = 1'b0;
      repeat (3) @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      wait_init(cycles, quiet);
      check({tag, "_init_cycles"}, cycles, 128);
      check({tag, "_outputs_quiet"}, quiet, 1);
   endtask

   task automatic wr_thresh(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] val);
      @(negedge clk_clk);
      thresh_we   = 1'b1;
      thresh_ch   = ch;
      thresh_data = val;
      @(posedge clk_clk);
      #1 thresh_we = 1'b0;
   endtask

   // One sample through the pipe; optionally writes this channel's threshold during its EMIT cycle.
   task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] data,
                       input bit wr_at_emit, input logic [DATA_W-1:0] wr_val,
                       output logic [DATA_W-1:0] env, output int lat);
      int waited;
      waited = 0;
      @(negedge clk_clk);
      while (!s_ready && waited < 50) begin
         @(negedge clk_clk);
         waited++;
      end
      if (!s_ready) check("s_ready_timeout", s_ready, 1);
      s_valid   = 1'b1;
      s_channel = ch;
      s_data    = data;
      @(posedge clk_clk);
      #1 s_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk_clk);
         lat++;
      end while (!env_valid && lat < 10);
      env = env_data;
      check("env_channel", env_channel, ch);
      if (wr_at_emit) begin
         thresh_we   = 1'b1;
         thresh_ch   = ch;
         thresh_data = wr_val;
      end
      @(posedge clk_clk);
      #1 thresh_we = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] env;
      int lat;
      int cycles;
      bit quiet;

      // Reset and INIT sweep
      do_reset("t1");

      // Ramp on ch2: rect 400 fills a zeroed window
      for (int i = 1; i <= 16; i++) begin
         send(3'd2, 12'd2448, 1'b0, '0, env, lat);
         check("t2_env", env, 25 * i);
         check("t2_latency", lat, 3);
      end

      // Hysteresis on ch2: set at 300, release below 236
      do_reset("t3");
      wr_thresh(3'd2, 12'd300);
      for (int i = 1; i <= 16; i++) begin
         send(3'd2, 12'd2448, 1'b0, '0, env, lat);
         check("t3_rise_det", detect[2], (i >= 12));
      end
      for (int j = 1; j <= 16; j++) begin
         send(3'd2, 12'd2048, 1'b0, '0, env, lat);
         check("t3_fall_env", env, 400 - 25 * j);
         check("t3_fall_det", detect[2], (j <= 6));
      end
      // Threshold write during EMIT of the same channel wins
      wr_thresh(3'd4, 12'd10);
      send(3'd4, 12'd2448, 1'b1, 12'd10, env, lat);
      check("t3_emit_wr_env", env, 25);
      check("t3_emit_wr_det", detect[4], 0);
      send(3'd4, 12'd2448, 1'b0, '0, env, lat);
      check("t3_after_wr_det", detect[4], 1);
      wr_thresh(3'd4, 12'd2000);
      check("t3_wr_clears", detect[4], 0);
      // Threshold at or below HYST: flag holds down to env 0
      wr_thresh(3'd6, 12'd40);
      send(3'd6, 12'd2448, 1'b0, '0, env, lat);
      check("t3_low_det_25", detect[6], 0);
      send(3'd6, 12'd2448, 1'b0, '0, env, lat);
      check("t3_low_det_50", detect[6], 1);
      for (int j = 1; j <= 16; j++) send(3'd6, 12'd2048, 1'b0, '0, env, lat);
      check("t3_low_env_0", env, 0);
      check("t3_detect_vec", detect, 8'b0100_0000);

      // Window wrap on ch5, ch1 untouched
      do_reset("t4");
      send(3'd1, 12'd2448, 1'b0, '0, env, lat);
      check("t4_ch1_first", env, 25);
      for (int i = 1; i <= 16; i++) begin
         send(3'd5, 12'd2848, 1'b0, '0, env, lat);
         check("t4_ch5_ramp", env, 50 * i);
      end
      send(3'd5, 12'd2048, 1'b0, '0, env, lat);
      check("t4_ch5_wrap", env, 750);
      send(3'd1, 12'd2448, 1'b0, '0, env, lat);
      check("t4_ch1_second", env, 50);
      check("t4_detect_thr0", detect, 8'b0010_0010);

      // LED bar for selected channel
      sel_ch = 3'd2;
      do_reset("t5");
      for (int i = 1; i <= 16; i++) send(3'd2, 12'd3648, 1'b0, '0, env, lat);
      check("t5_env_1600", env, 1600);
      check("t5_led_1600", led_bar, 6'b000111);
      for (int i = 1; i <= 16; i++) send(3'd2, 12'd0, 1'b0, '0, env, lat);
      check("t5_env_2048", env, 2048);
      check("t5_led_2048", led_bar, 6'b001111);
      send(3'd3, 12'd3648, 1'b0, '0, env, lat);
      check("t5_other_ch_env", env, 100);
      check("t5_led_hold", led_bar, 6'b001111);
      @(negedge clk_clk);
      sel_ch = 3'd3;
      @(negedge clk_clk);
      check("t5_sel_no_emit", led_bar, 6'b001111);
      send(3'd3, 12'd3648, 1'b0, '0, env, lat);
      check("t5_sel_ch3_env", env, 200);
      check("t5_sel_ch3_led", led_bar, 6'b000000);

      // Reset during UPDATE drops the in-flight sample
      do_reset("t6");
      send(3'd2, 12'd2448, 1'b0, '0, env, lat);
      check("t6_pre_env", env, 25);
      @(negedge clk_clk);
      s_valid   = 1'b1;
      s_channel = 3'd2;
      s_data    = 12'd2448;
      @(posedge clk_clk);
      #1 s_valid = 1'b0;
      @(posedge clk_clk);
      #1 reset_reset = 1'b1;
      @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      wait_init(cycles, quiet);
      check("t6_init_cycles", cycles, 128);
      check("t6_outputs_quiet", quiet, 1);
      send(3'd2, 12'd2448, 1'b0, '0, env, lat);
      check("t6_post_env", env, 25);
      check("t6_post_latency", lat, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
